wfg_stim_mem_arb: RTL and testbench
===================================

WFG_STIM_MEM_ARB -- requirements
Module: wfg_stim_mem_arb

Interface
REQ-001 Parameter NREQ, default 2, number of read requesters (2..4).
REQ-002 Parameter AW, default 10, memory word-address width.
REQ-003 Parameter DW, default 32, memory data width.
REQ-004 wb_clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 wb_rst_i  in  1  reset; one clock, reset synchronous and active-high.
REQ-006 arb_en_i  in  1  arbiter enable; 0 blocks new grants, drains in-flight read.
REQ-007 req_i  in  NREQ  per-requester read request; held with address stable until granted.
REQ-008 addr_i  in  NREQ*AW  packed request addresses; slice k belongs to requester k.
REQ-009 gnt_o  out  NREQ  one-hot grant; request k accepted in the cycle gnt_o[k]=1.
REQ-010 rvalid_o  out  NREQ  one-hot read-data valid, one cycle after the matching grant.
REQ-011 rdata_o  out  DW  read data, shared by all requesters; qualified by rvalid_o.
REQ-012 csb1  out  1  memory chip select, active low.
REQ-013 addr1  out  AW  memory address.
REQ-014 dout1  in  DW  memory read data, valid one cycle after csb1=0.

Function
REQ-015 At most one requester granted per cycle; one read issued per granted cycle, back-to-back allowed.
REQ-016 Grant combinational from req_i, arb_en_i and round-robin pointer; csb1=0 and addr1=addr_i[granted] in the grant cycle, else csb1=1, addr1=0.
REQ-017 Round-robin: search starts at index (last_granted+1) mod NREQ; pointer updates only on a grant.
REQ-018 Pipeline register captures granted one-hot index; rvalid_o equals it next cycle; rdata_o=dout1 when any rvalid_o set, else 0.
REQ-019 Read latency grant-to-rvalid exactly 1 cycle; no requests dropped, no reordering.
REQ-020 arb_en_i=0: gnt_o=0, csb1=1; a read granted the previous cycle still returns rvalid.
REQ-021 Single requester active: granted every cycle it requests.
REQ-022 Requester that drops req_i before grant is not granted; no memory access for it.
REQ-023 Pointer wrap: after index NREQ-1 granted, search starts at 0.

Reset
REQ-024 While wb_rst_i=1: gnt_o=0, rvalid_o=0, rdata_o=0, csb1=1, addr1=0, pointer=NREQ-1 (requester 0 highest after reset), lock state cleared.
REQ-025 Reset asserted mid-read: pending rvalid discarded; first cycle after reset behaves as idle.

Configuration
REQ-026 Macro WFG_STIM_MEM_ARB_LOCK_EN adds input lock_i[NREQ]; with it, a granted requester holding req_i and lock_i keeps the grant on following cycles, pointer frozen until lock_i or req_i drops.
REQ-027 Without WFG_STIM_MEM_ARB_LOCK_EN no lock_i port exists; pure round-robin per REQ-017.
REQ-028 Lock ignored while arb_en_i=0; lock cleared when arb_en_i falls.

Structure
REQ-029 Package wfg_stim_mem_arb_pkg holds default NREQ/AW/DW constants and the round-robin next-index function.
REQ-030 Sub-module wfg_rr_picker: combinational rotate-priority one-hot picker (req, pointer -> one-hot grant).
REQ-031 Instantiated between wfg_stim_mem instances and the shared stimulus SRAM read port.

Verification
REQ-032 NREQ=2, both req_i held 6 cycles, addr 0x010/0x020 -> gnt 01,10,01,10,01,10; rvalid same pattern one cycle later; rdata = dout1 of each address.
REQ-033 Only req_i[1] held 4 cycles, addr 0x3FF -> gnt_o[1]=1 each cycle, csb1=0, addr1=0x3FF, four rvalid_o[1] pulses.
REQ-034 Both requesting, arb_en_i driven 0 after first grant -> gnt_o=0, csb1=1 from that cycle, one trailing rvalid_o only.
REQ-035 wb_rst_i pulsed one cycle right after a grant -> no rvalid_o next cycle, outputs at reset values, next grant goes to requester 0.
REQ-036 LOCK_EN build, requester 0 lock_i=1 for 3 cycles with requester 1 requesting -> gnt_o=01 three cycles, then 10.
REQ-037 req_i[0] pulsed for one cycle while requester 1 holds the grant slot -> req_i[0] never granted, csb1 count equals requester 1 grants only.

Source files
------------

// File: rtl/wfg_stim_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : wfg_stim_mem_arb_pkg
// Brief  : Default sizing constants and round-robin helper for the stimulus
//          memory read arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package wfg_stim_mem_arb_pkg;

    localparam int DEFAULT_NREQ = 2;
    localparam int DEFAULT_AW   = 10;
    localparam int DEFAULT_DW   = 32;

    // Index that follows 'last' in a ring of n requesters.
    function automatic int rr_next(input int last, input int n);
        return (last + 1 >= n) ? 0 : last + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wfg_rr_picker.sv
`default_nettype none
// ============================================================================
// Module : wfg_rr_picker
// Brief  : Combinational rotate-priority picker; highest priority is the
//          index just after ptr, result is one-hot (or zero if no request).
// Rev    : 1.0  initial release
// ============================================================================
module wfg_rr_picker
    import wfg_stim_mem_arb_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int PW   = $clog2(DEFAULT_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    int   w_cand;
    logic w_found;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = (rr_next(int'(ptr), NREQ) + i) % NREQ;
            if (!w_found && req[w_cand[PW-1:0]]) begin
                gnt[w_cand[PW-1:0]] = 1'b1;
                w_found             = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wfg_stim_mem_arb.sv
`default_nettype none
// ============================================================================
// Module : wfg_stim_mem_arb
// Brief  : Round-robin arbiter sharing one stimulus SRAM read port among
//          NREQ requesters; one-cycle read latency, back-to-back grants.
//          Optional grant locking enabled by WFG_STIM_MEM_ARB_LOCK_EN.
// Rev    : 1.0  initial release
// ============================================================================
module wfg_stim_mem_arb
    import wfg_stim_mem_arb_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int AW   = DEFAULT_AW,
    parameter int DW   = DEFAULT_DW
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             arb_en_i,
    input  logic [NREQ-1:0]  req_i,
    input  logic [NREQ*AW-1:0] addr_i,
`ifdef WFG_STIM_MEM_ARB_LOCK_EN
    input  logic [NREQ-1:0]  lock_i,
`endif
    output logic [NREQ-1:0]  gnt_o,
    output logic [NREQ-1:0]  rvalid_o,
    output logic [DW-1:0]    rdata_o,
    output logic             csb1,
    output logic [AW-1:0]    addr1,
    input  logic [DW-1:0]    dout1
);

    localparam int             c_PW      = $clog2(NREQ);
    localparam logic [c_PW-1:0] c_PTR_RST = c_PW'(NREQ - 1);

    logic [c_PW-1:0] r_ptr;
    logic [NREQ-1:0] r_rvalid;
    logic [NREQ-1:0] w_pick;
    logic [NREQ-1:0] w_gnt;
    logic [c_PW-1:0] w_gnt_idx;
    logic            w_lock_hold;

    wfg_rr_picker #(
        .NREQ (NREQ),
        .PW   (c_PW)
    ) u_picker (
        .req (req_i),
        .ptr (r_ptr),
        .gnt (w_pick)
    );

`ifdef WFG_STIM_MEM_ARB_LOCK_EN
    logic            r_lock_act;
    logic [NREQ-1:0] r_lock_vec;

    assign w_lock_hold = r_lock_act && arb_en_i && !wb_rst_i
                         && |(r_lock_vec & req_i & lock_i);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !arb_en_i) begin
            r_lock_act <= 1'b0;
            r_lock_vec <= '0;
        end else if (|(w_gnt & lock_i)) begin
            r_lock_act <= 1'b1;
            r_lock_vec <= w_gnt;
        end else begin
            r_lock_act <= 1'b0;
            r_lock_vec <= '0;
        end
    end

    always_comb begin
        w_gnt = '0;
        if (!wb_rst_i && arb_en_i)
            w_gnt = w_lock_hold ? r_lock_vec : w_pick;
    end
`else
    assign w_lock_hold = 1'b0;
    assign w_gnt       = (!wb_rst_i && arb_en_i) ? w_pick : '0;
`endif

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (w_gnt[i]) w_gnt_idx = i[c_PW-1:0];
    end

    // A locked grant keeps the pointer where the lock began.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ptr    <= c_PTR_RST;
            r_rvalid <= '0;
        end else begin
            r_rvalid <= w_gnt;
            if (|w_gnt && !w_lock_hold)
                r_ptr <= w_gnt_idx;
        end
    end

    assign gnt_o    = w_gnt;
    assign csb1     = ~|w_gnt;
    assign addr1    = |w_gnt ? addr_i[w_gnt_idx*AW +: AW] : '0;
    assign rvalid_o = wb_rst_i ? '0 : r_rvalid;
    assign rdata_o  = |rvalid_o ? dout1 : '0;

endmodule
`default_nettype wire

// File: tb/tb_wfg_stim_mem_arb.sv
`default_nettype none
// Directed table-driven bench for wfg_stim_mem_arb (NREQ=2, AW=10, DW=32)
// with a one-cycle-latency SRAM model on the memory port.
module tb_wfg_stim_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  req;
    logic [19:0] addr;
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata, dout1;
    logic        csb1;
    logic [9:0]  maddr;
`ifdef WFG_STIM_MEM_ARB_LOCK_EN
    logic [1:0]  lock;
`endif

    int tests  = 0;
    int failed = 0;
    int csb_cnt = 0;

    always #5 clk = ~clk;

    wfg_stim_mem_arb #(.NREQ(2), .AW(10), .DW(32)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .arb_en_i (en),
        .req_i    (req),
        .addr_i   (addr),
`ifdef WFG_STIM_MEM_ARB_LOCK_EN
        .lock_i   (lock),
`endif
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .csb1     (csb1),
        .addr1    (maddr),
        .dout1    (dout1)
    );

    function automatic logic [31:0] mdata(input logic [9:0] a);
        return 32'hA500_0000 | {22'd0, a};
    endfunction

    always @(posedge clk)
        if (!csb1) dout1 <= mdata(maddr);

    typedef struct {
        int          seg;
        logic        rst;
        logic        en;
        logic [1:0]  req;
        logic [9:0]  a0;
        logic [9:0]  a1;
        logic [1:0]  egnt;
        logic [1:0]  erv;
        logic        ecsb;
        logic [9:0]  eaddr;
        logic [31:0] erd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int seg, input logic r, input logic e, input logic [1:0] rq,
                       input logic [9:0] a0, input logic [9:0] a1,
                       input logic [1:0] eg, input logic [1:0] ev, input logic ec,
                       input logic [9:0] ea, input logic [31:0] ed);
        vec_t v;
        v.seg = seg; v.rst = r; v.en = e; v.req = rq; v.a0 = a0; v.a1 = a1;
        v.egnt = eg; v.erv = ev; v.ecsb = ec; v.eaddr = ea; v.erd = ed;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; req = 2'b00; addr = '0; dout1 = '0;
`ifdef WFG_STIM_MEM_ARB_LOCK_EN
        lock = 2'b00;
`endif
        // reset
        add(0, 1, 1, 2'b11, 10'h010, 10'h020, 2'b00, 2'b00, 1, 10'h000, 32'h0);
        add(0, 1, 1, 2'b11, 10'h010, 10'h020, 2'b00, 2'b00, 1, 10'h000, 32'h0);
        // both requesting: alternate, requester 0 first
        add(1, 0, 1, 2'b11, 10'h010, 10'h020, 2'b01, 2'b00, 0, 10'h010, 32'h0);
        add(1, 0, 1, 2'b11, 10'h010, 10'h020, 2'b10, 2'b01, 0, 10'h020, mdata(10'h010));
        add(1, 0, 1, 2'b11, 10'h010, 10'h020, 2'b01, 2'b10, 0, 10'h010, mdata(10'h020));
        add(1, 0, 1, 2'b11, 10'h010, 10'h020, 2'b10, 2'b01, 0, 10'h020, mdata(10'h010));
        add(1, 0, 1, 2'b11, 10'h010, 10'h020, 2'b01, 2'b10, 0, 10'h010, mdata(10'h020));
        add(1, 0, 1, 2'b11, 10'h010, 10'h020, 2'b10, 2'b01, 0, 10'h020, mdata(10'h010));
        add(1, 0, 1, 2'b00, 10'h010, 10'h020, 2'b00, 2'b10, 1, 10'h000, mdata(10'h020));
        add(1, 0, 1, 2'b00, 10'h010, 10'h020, 2'b00, 2'b00, 1, 10'h000, 32'h0);
        // single requester at top address
        add(2, 0, 1, 2'b10, 10'h010, 10'h3FF, 2'b10, 2'b00, 0, 10'h3FF, 32'h0);
        add(2, 0, 1, 2'b10, 10'h010, 10'h3FF, 2'b10, 2'b10, 0, 10'h3FF, mdata(10'h3FF));
        add(2, 0, 1, 2'b10, 10'h010, 10'h3FF, 2'b10, 2'b10, 0, 10'h3FF, mdata(10'h3FF));
        add(2, 0, 1, 2'b10, 10'h010, 10'h3FF, 2'b10, 2'b10, 0, 10'h3FF, mdata(10'h3FF));
        add(2, 0, 1, 2'b00, 10'h010, 10'h3FF, 2'b00, 2'b10, 1, 10'h000, mdata(10'h3FF));
        add(2, 0, 1, 2'b00, 10'h010, 10'h3FF, 2'b00, 2'b00, 1, 10'h000, 32'h0);
        // disable after first grant: one trailing rvalid
        add(3, 0, 1, 2'b11, 10'h010, 10'h020, 2'b01, 2'b00, 0, 10'h010, 32'h0);
        add(3, 0, 0, 2'b11, 10'h010, 10'h020, 2'b00, 2'b01, 1, 10'h000, mdata(10'h010));
        add(3, 0, 0, 2'b11, 10'h010, 10'h020, 2'b00, 2'b00, 1, 10'h000, 32'h0);
        add(3, 0, 1, 2'b00, 10'h010, 10'h020, 2'b00, 2'b00, 1, 10'h000, 32'h0);
        // reset pulse right after a grant
        add(4, 0, 1, 2'b11, 10'h010, 10'h020, 2'b10, 2'b00, 0, 10'h020, 32'h0);
        add(4, 1, 1, 2'b11, 10'h010, 10'h020, 2'b00, 2'b00, 1, 10'h000, 32'h0);
        add(4, 0, 1, 2'b11, 10'h010, 10'h020, 2'b01, 2'b00, 0, 10'h010, 32'h0);
        add(4, 0, 1, 2'b00, 10'h010, 10'h020, 2'b00, 2'b01, 1, 10'h000, mdata(10'h010));
        // one-cycle req_i[0] pulse that loses to requester 1
        add(5, 0, 1, 2'b11, 10'h010, 10'h020, 2'b10, 2'b00, 0, 10'h020, 32'h0);
        add(5, 0, 1, 2'b10, 10'h010, 10'h020, 2'b10, 2'b10, 0, 10'h020, mdata(10'h020));
        add(5, 0, 1, 2'b10, 10'h010, 10'h020, 2'b10, 2'b10, 0, 10'h020, mdata(10'h020));
        add(5, 0, 1, 2'b00, 10'h010, 10'h020, 2'b00, 2'b10, 1, 10'h000, mdata(10'h020));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst  = vecs[i].rst;
            en   = vecs[i].en;
            req  = vecs[i].req;
            addr = {vecs[i].a1, vecs[i].a0};
            @(negedge clk);
            chk("gnt",    i, 32'(gnt),    32'(vecs[i].egnt));
            chk("rvalid", i, 32'(rvalid), 32'(vecs[i].erv));
            chk("csb1",   i, 32'(csb1),   32'(vecs[i].ecsb));
            chk("addr1",  i, 32'(maddr),  32'(vecs[i].eaddr));
            chk("rdata",  i, rdata,       vecs[i].erd);
            if (vecs[i].seg == 5 && !csb1) csb_cnt++;
        end
        chk("csb_count_pulse", 0, 32'(csb_cnt), 32'd3);

`ifdef WFG_STIM_MEM_ARB_LOCK_EN
        // requester 0 locks for three cycles, then requester 1 is served
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            req  = 2'b11;
            lock = (k < 3) ? 2'b01 : 2'b00;
            @(negedge clk);
            chk("lock_gnt", k, 32'(gnt), (k < 3) ? 32'd1 : 32'd2);
        end
        @(posedge clk);
        #1;
        req = 2'b00; lock = 2'b00;
`endif

        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
